mcycle_flag_unit: RTL and testbench



---
 rtl/mcycle_flag_unit_if.sv | 28 ++
 rtl/mcycle_flag_unit.sv | 170 +++++++++++++++++
 tb/tb_mcycle_flag_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mcycle_flag_unit_if.sv
// Bus between the controller and the multi-cycle multiply/divide flag unit.
// The controller side uses the master modport and the arithmetic unit uses the slave modport.
interface mcycle_flag_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Start;
    logic             MCycleOp;
    logic             S;
    logic             CarryIn;
    logic             OverflowIn;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result;
    logic             Busy;
    logic             Done;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;

    modport master (
        output Start, MCycleOp, S, CarryIn, OverflowIn, Operand1, Operand2,
        input  Result, Busy, Done, ALUFlags, FlagW
    );

    modport slave (
        input  Start, MCycleOp, S, CarryIn, OverflowIn, Operand1, Operand2,
        output Result, Busy, Done, ALUFlags, FlagW
    );
endinterface

// File: rtl/mcycle_flag_unit.sv
// Iterative unsigned multiply (low word) / restoring divide, one bit per cycle.
// The unit produces the {N,Z,C,V} flags and the FlagW enables for the condition unit.
// C and V are passed through from the values latched at Start, and only N/Z are ever enabled.
// Build option MCYCLE_DIV_EN: when it is defined, the restoring divider is compiled in.
// When it is undefined, a UDIV request completes in one cycle with a quotient of 0.
module mcycle_flag_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic                CLK,
    input logic                Reset,
    mcycle_flag_unit_if.slave  bus
);
    localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic             s_q, s_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    // a: multiplicand (MUL) or dividend/quotient shift register (UDIV)
    logic [WIDTH-1:0] a_q, a_d;
    // b: multiplier (MUL, shifted right) or divisor (UDIV)
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [3:0]       flags_q, flags_d;
    logic [1:0]       flagw_q, flagw_d;

    logic [WIDTH-1:0] mul_next;
    logic [WIDTH-1:0] final_val;

`ifdef MCYCLE_DIV_EN
    logic             op_q, op_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] diff;
    logic             qbit;
`endif

    // One iteration of each datapath, evaluated from the current registers
    always_comb begin
        mul_next = acc_q + (b_q[0] ? a_q : '0);
`ifdef MCYCLE_DIV_EN
        rem_sh = {rem_q, a_q[WIDTH-1]};
        diff   = rem_sh - {2'b00, b_q};
        // No borrow means the divisor fits, so the quotient bit is 1
        qbit   = ~diff[WIDTH+1];
`endif
    end

    // Next-state logic, operand latching and flag generation
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        c_d       = c_q;
        v_d       = v_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        result_d  = result_q;
        count_d   = count_q;
        flags_d   = flags_q;
        flagw_d   = 2'b00;
        final_val = mul_next;
`ifdef MCYCLE_DIV_EN
        op_d      = op_q;
        rem_d     = rem_q;
`endif

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.Start) begin
                    s_d     = bus.S;
                    c_d     = bus.CarryIn;
                    v_d     = bus.OverflowIn;
                    a_d     = bus.Operand1;
                    b_d     = bus.Operand2;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = StRun;
`ifdef MCYCLE_DIV_EN
                    op_d    = bus.MCycleOp;
                    rem_d   = '0;
`else
                    // Without a divider, UDIV completes immediately with a zero quotient
                    if (bus.MCycleOp) begin
                        state_d  = StDone;
                        result_d = '0;
                        flags_d  = {1'b0, 1'b1, bus.CarryIn, bus.OverflowIn};
                        flagw_d  = bus.S ? 2'b10 : 2'b00;
                    end
`endif
                end
            end

            StRun: begin
                count_d = count_q + CntW'(1);
`ifdef MCYCLE_DIV_EN
                if (op_q) begin
                    rem_d     = qbit ? diff[WIDTH:0] : rem_sh[WIDTH:0];
                    a_d       = {a_q[WIDTH-2:0], qbit};
                    final_val = {a_q[WIDTH-2:0], qbit};
                end else
`endif
                begin
                    acc_d     = mul_next;
                    a_d       = a_q << 1;
                    b_d       = b_q >> 1;
                    final_val = mul_next;
                end
                if (count_q == LastCnt) begin
                    state_d  = StDone;
                    count_d  = '0;
                    result_d = final_val;
                    flags_d  = {final_val[WIDTH-1], final_val == '0, c_q, v_q};
                    flagw_d  = s_q ? 2'b10 : 2'b00;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // State registers; reset wins over any operation in flight
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= StIdle;
            s_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            count_q  <= '0;
            flags_q  <= '0;
            flagw_q  <= '0;
`ifdef MCYCLE_DIV_EN
            op_q     <= 1'b0;
            rem_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            c_q      <= c_d;
            v_q      <= v_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
            flagw_q  <= flagw_d;
`ifdef MCYCLE_DIV_EN
            op_q     <= op_d;
            rem_q    <= rem_d;
`endif
        end
    end

    assign bus.Result   = result_q;
    assign bus.Busy     = (state_q == StRun);
    assign bus.Done     = (state_q == StDone);
    assign bus.ALUFlags = flags_q;
    assign bus.FlagW    = flagw_q;
endmodule

// File: tb/tb_mcycle_flag_unit.sv
// Directed testbench for mcycle_flag_unit.
// UDIV expectations follow the MCYCLE_DIV_EN build option.
module tb_mcycle_flag_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mcycle_flag_unit_if #(.WIDTH(32)) bus ();

    mcycle_flag_unit #(.WIDTH(32)) dut (
        .CLK   (clk),
        .Reset (reset),
        .bus   (bus)
    );

`ifdef MCYCLE_DIV_EN
    localparam int DivLat = 33;
    localparam bit DivOn  = 1'b1;
`else
    localparam int DivLat = 1;
    localparam bit DivOn  = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic c, input logic v);
        bus.Start      = 1'b1;
        bus.MCycleOp   = op;
        bus.Operand1   = a;
        bus.Operand2   = b;
        bus.S          = s;
        bus.CarryIn    = c;
        bus.OverflowIn = v;
    endtask

    // Hold Start through one edge, then scramble the inputs to prove they were latched
    task automatic start_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic c, input logic v);
        drive(op, a, b, s, c, v);
        @(posedge clk);
        #1;
        bus.Start      = 1'b0;
        bus.Operand1   = $urandom;
        bus.Operand2   = $urandom;
        bus.S          = ~s;
        bus.CarryIn    = ~c;
        bus.OverflowIn = ~v;
        bus.MCycleOp   = ~op;
    endtask

    // Sample each cycle on the falling edge until Done, with a bounded budget
    task automatic wait_done(input int first, output int cyc, output int busy_miss,
                             output int fw_bad);
        cyc = 0;
        busy_miss = 0;
        fw_bad = 0;
        for (int i = first; i < first + 45; i++) begin
            @(negedge clk);
            if (bus.Done) begin
                cyc = i;
                break;
            end
            if (!bus.Busy) busy_miss++;
            if (bus.FlagW != 2'b00) fw_bad++;
        end
    endtask

    task automatic verify(input string tag, input int cyc, input int busy_miss, input int fw_bad,
                          input int exp_cyc, input logic [31:0] exp_res,
                          input logic [3:0] exp_flags, input logic [1:0] exp_fw);
        check({tag, ".done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, ".busy_gaps"}, 32'(busy_miss), 32'd0);
        check({tag, ".flagw_early"}, 32'(fw_bad), 32'd0);
        check({tag, ".busy_at_done"}, 32'(bus.Busy), 32'd0);
        check({tag, ".result"}, bus.Result, exp_res);
        check({tag, ".flags"}, 32'(bus.ALUFlags), 32'(exp_flags));
        check({tag, ".flagw"}, 32'(bus.FlagW), 32'(exp_fw));
    endtask

    task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                          input logic [31:0] b, input logic s, input logic c, input logic v,
                          input int exp_cyc, input logic [31:0] exp_res,
                          input logic [3:0] exp_flags, input logic [1:0] exp_fw);
        int cyc, bm, fb;
        start_op(op, a, b, s, c, v);
        wait_done(1, cyc, bm, fb);
        verify(tag, cyc, bm, fb, exp_cyc, exp_res, exp_flags, exp_fw);
    endtask

    initial begin
        int cyc, bm, fb, dones;
        reset          = 1'b1;
        bus.Start      = 1'b0;
        bus.MCycleOp   = 1'b0;
        bus.S          = 1'b0;
        bus.CarryIn    = 1'b0;
        bus.OverflowIn = 1'b0;
        bus.Operand1   = '0;
        bus.Operand2   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.result", bus.Result, 32'd0);
        check("rst.busy", 32'(bus.Busy), 32'd0);
        check("rst.done", 32'(bus.Done), 32'd0);
        check("rst.flags", 32'(bus.ALUFlags), 32'd0);
        check("rst.flagw", 32'(bus.FlagW), 32'd0);
        reset = 1'b0;

        run_op("mul_7x6", 1'b0, 32'd7, 32'd6, 1'b1, 1'b1, 1'b0, 33, 32'd42, 4'b0010, 2'b10);
        run_op("mul_wrap0", 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 1'b1,
               33, 32'd0, 4'b0101, 2'b10);
        run_op("mul_neg", 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 1'b0,
               33, 32'hFFFF_FFFE, 4'b1000, 2'b10);
        run_op("mul_s0", 1'b0, 32'h1234_5678, 32'h10, 1'b0, 1'b1, 1'b1,
               33, 32'h2345_6780, 4'b0011, 2'b00);
        // Result holds after DONE while the pulse and enables drop
        @(negedge clk);
        @(negedge clk);
        check("hold.result", bus.Result, 32'h2345_6780);
        check("hold.done", 32'(bus.Done), 32'd0);
        check("hold.flagw", 32'(bus.FlagW), 32'd0);

        run_op("udiv_100_7", 1'b1, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, DivLat,
               DivOn ? 32'd14 : 32'd0, DivOn ? 4'b0000 : 4'b0100, 2'b00);
        run_op("udiv_5_0", 1'b1, 32'd5, 32'd0, 1'b1, 1'b1, 1'b0, DivLat,
               DivOn ? 32'hFFFF_FFFF : 32'd0, DivOn ? 4'b1010 : 4'b0110, 2'b10);
        run_op("udiv_max_3", 1'b1, 32'hFFFF_FFFF, 32'd3, 1'b1, 1'b0, 1'b1, DivLat,
               DivOn ? 32'h5555_5555 : 32'd0, DivOn ? 4'b0001 : 4'b0101, 2'b10);

        // Start pulsed in cycle 10 of a running MUL must be ignored
        start_op(1'b0, 32'd3, 32'd5, 1'b1, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        drive(1'b0, 32'd100, 32'd100, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        wait_done(11, cyc, bm, fb);
        verify("ignore_start", cyc, bm, fb, 33, 32'd15, 4'b0000, 2'b10);

        // Back-to-back: Start held in the DONE cycle
        start_op(1'b0, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0);
        wait_done(1, cyc, bm, fb);
        verify("b2b_first", cyc, bm, fb, 33, 32'd81, 4'b0000, 2'b10);
        drive(1'b0, 32'h8000_0000, 32'd1, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        wait_done(1, cyc, bm, fb);
        verify("b2b_second", cyc, bm, fb, 33, 32'h8000_0000, 4'b1011, 2'b10);

        // One-cycle reset in cycle 15 of a UDIV aborts it
        start_op(1'b1, 32'd1000, 32'd3, 1'b1, 1'b0, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort.busy", 32'(bus.Busy), 32'd0);
        check("abort.done", 32'(bus.Done), 32'd0);
        check("abort.result", bus.Result, 32'd0);
        check("abort.flagw", 32'(bus.FlagW), 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.Done) dones++;
        end
        check("abort.no_done", 32'(dones), 32'd0);

        run_op("mul_recover", 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0,
               33, 32'hFFFE_0001, 4'b1000, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
